mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative signed 32-bit multiply/divide unit feeding the HI/LO Register pair.
//  Accepts a one-cycle start pulse and computes over multiple cycles.
//  Presents result_lo/result_hi with a one-cycle result_rdy pulse, which drives
//  the en input of both destination Registers.
// PARAMETERS
//  WIDTH     32   operand/result width (only 32 supported by the tests)
//  ITER      32   iterations per operation (WIDTH / 2 when MULTDIV_BOOTH4_EN is defined)
// PORTS
//  clk          in   1      rising-edge clock
//  clr          in   1      asynchronous, active-low reset
//  op_a         in   WIDTH  multiplicand / dividend (signed)
//  op_b         in   WIDTH  multiplier / divisor (signed)
//  start_mult   in   1      one-cycle pulse: start op_a*op_b
//  start_div    in   1      one-cycle pulse: start op_a/op_b
//  result_lo    out  WIDTH  product[31:0] / quotient
//  result_hi    out  WIDTH  product[63:32] / remainder
//  exception    out  1      valid with result_rdy: mult overflow or divide by zero
//  result_rdy   out  1      one-cycle pulse: results valid (Register en)
//  busy         out  1      high in MULT, DIV and DONE states
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE; result_lo, result_hi, exception,
//   result_rdy, busy all 0; counter 0.
//  States: IDLE, MULT, DIV, DONE.
//   IDLE -> MULT on start_mult; IDLE -> DIV on start_div.
//   If both starts are high, start_mult wins.
//   On acceptance, op_a/op_b are captured; later operand changes are ignored.
//   MULT/DIV: one iteration per cycle; after ITER iterations -> DONE.
//   DONE: result_rdy=1 for exactly one cycle, then -> IDLE.
//  Latency: start sampled at edge k -> result_rdy high from edge k+ITER+1 to k+ITER+2.
//   Default ITER=32 gives result_rdy 33 cycles after start.
//  Starts seen in MULT, DIV or DONE are ignored; there is no queueing.
//   Back-to-back operation is possible from the cycle after DONE.
//  Multiply: shift-add on magnitudes; sign fix-up at the end.
//   Full 64-bit product goes to {result_hi, result_lo}.
//   exception=1 iff the product does not fit in signed 32 bits
//   (result_hi != sign-extension of result_lo[31]).
//  Divide: restoring division on magnitudes.
//   Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (truncating).
//  Divide by zero (op_b==0): skip iterations, go straight to DONE.
//   result_rdy at edge k+2; result_lo=0, result_hi=op_a, exception=1.
//  0x80000000 / -1: result_lo=0x80000000, result_hi=0, exception=0.
//  Outputs hold their last values while IDLE.
//  exception is meaningful only while result_rdy=1 and clears on the next start.
//  clr asserted mid-operation: abort immediately; no result_rdy is produced.
// CONFIGURATION
//  MULTDIV_BOOTH4_EN defined: multiply uses radix-4 Booth recoding.
//   ITER=16 for MULT, giving result_rdy at k+17. Divide is unchanged (k+33).
//  Not defined: radix-2 shift-add; MULT latency is k+33.
//  Products and exception flags are identical in both builds.
// STRUCTURE
//  Shared package multdiv_pkg:
//   state enum {IDLE, MULT, DIV, DONE}
//   op enum {OP_MULT, OP_DIV}
//   localparams ITER_RADIX2=32, ITER_BOOTH4=16
//  One sub-module, mdu_iter_counter: loadable down-counter asserting last_iter.
//  Datapath (accumulator, shift registers, sign fix-up) lives in the top module.
// TESTING
//  Reset: hold clr=0 with starts toggling -> all outputs 0, busy=0, no result_rdy.
//  Mult: a=7, b=-6 -> result_lo=0xFFFFFFD6, result_hi=0xFFFFFFFF, exception=0.
//   result_rdy at cycle 33 (17 with MULTDIV_BOOTH4_EN).
//  Mult overflow: a=0x00010000, b=0x00010000 -> result_lo=0, result_hi=1, exception=1.
//  Div: a=-7, b=2 -> result_lo=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1), rdy at cycle 33.
//  Div by zero: a=5, b=0 -> result_rdy at cycle 2, result_lo=0, result_hi=5, exception=1.
//  Busy/abort: start_div mid-MULT is ignored; clr pulsed at iteration 10 ->
//   IDLE, no result_rdy; the next start runs a full-length operation.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   state_t : control FSM states
//   op_t    : operation captured at start
//   ITER_RADIX2 / ITER_BOOTH4 : iterations per multiply for each build
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;

  localparam int ITER_RADIX2 = 32;
  localparam int ITER_BOOTH4 = 16;
endpackage

// File: rtl/mdu_iter_counter.sv
// Loadable down-counter for the multiply/divide iteration loop.
//   clk       : rising-edge clock
//   clr       : asynchronous active-low reset
//   load      : load load_val (takes priority over en)
//   load_val  : iteration count for the new operation
//   en        : decrement by one (saturates at zero)
//   last_iter : current cycle performs the final iteration
module mdu_iter_counter #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          last_iter
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                      count <= '0;
    else if (load)                 count <= load_val;
    else if (en && count != '0)    count <= count - 1'b1;
  end

  assign last_iter = (count == CW'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit feeding a HI/LO register pair.
// Optional build macro: MULTDIV_BOOTH4_EN selects radix-4 Booth multiply
// (16 iterations); otherwise radix-2 shift-add on magnitudes (32 iterations).
// Divide is restoring division on magnitudes in both builds.
//   clk        : rising-edge clock
//   clr        : asynchronous active-low reset
//   op_a/op_b  : signed operands, captured when a start is accepted
//   start_mult : one-cycle pulse, start op_a*op_b (wins over start_div)
//   start_div  : one-cycle pulse, start op_a/op_b
//   result_lo  : product[31:0] / quotient
//   result_hi  : product[63:32] / remainder
//   exception  : multiply overflow or divide by zero, valid with result_rdy
//   result_rdy : one-cycle pulse, results valid
//   busy       : operation in flight (MULT, DIV, DONE)
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  =
`ifdef MULTDIV_BOOTH4_EN
    ITER_BOOTH4
`else
    ITER_RADIX2
`endif
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             start_mult,
  input  logic             start_div,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  // Booth digits reach +/-2*a, so the upper accumulator needs two guard bits;
  // radix-2 only needs one for the adder carry.
`ifdef MULTDIV_BOOTH4_EN
  localparam int HW = WIDTH + 2;
`else
  localparam int HW = WIDTH + 1;
`endif

  state_t state_q, state_d;
  op_t    op_q;

  logic [HW-1:0]    acc_hi;   // product high / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0] mcand;    // multiplicand
  logic [WIDTH-1:0] mag_b;    // divisor magnitude
  logic             neg_lo;   // negate product / quotient at the end
  logic             neg_hi;   // negate remainder (dividend sign)
`ifdef MULTDIV_BOOTH4_EN
  logic             booth_x;  // bit shifted out below acc_lo[0]
`endif

  logic             cnt_load, cnt_en, last_iter;
  logic [CW-1:0]    cnt_load_val;

  mdu_iter_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .last_iter(last_iter)
  );

  assign busy = (state_q != IDLE);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = CW'(ITER);
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d  = MULT;
          cnt_load = 1'b1;
        end else if (start_div) begin
          state_d      = DIV;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(WIDTH);
        end
      end
      MULT: begin
        cnt_en = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DIV: begin
        // zero divisor spends exactly one cycle here, then reports
        if (mag_b == '0) state_d = DONE;
        else begin
          cnt_en = 1'b1;
          if (last_iter) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath helpers ----------------
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, a_fix;

  assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;

  // restoring step: shift next dividend bit into the remainder, try subtract
  assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b0, mag_b};

  assign prod     = {acc_hi[WIDTH-1:0], acc_lo};
  assign prod_fix = neg_lo ? -prod : prod;
  assign q_fix    = neg_lo ? -acc_lo : acc_lo;
  assign r_fix    = neg_hi ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
  // acc_lo still holds |op_a| when the divisor was zero
  assign a_fix    = neg_hi ? -acc_lo : acc_lo;

`ifdef MULTDIV_BOOTH4_EN
  logic [HW-1:0] mc_ext, booth_add, booth_sum;
  assign mc_ext = {{2{mcand[WIDTH-1]}}, mcand};
  always_comb begin
    booth_add = '0;
    case ({acc_lo[1:0], booth_x})
      3'b001, 3'b010: booth_add = mc_ext;
      3'b011:         booth_add = mc_ext << 1;
      3'b100:         booth_add = -(mc_ext << 1);
      3'b101, 3'b110: booth_add = -mc_ext;
      default:        booth_add = '0;
    endcase
  end
  assign booth_sum = acc_hi + booth_add;
`else
  logic [HW-1:0] mul_sum;
  assign mul_sum = acc_hi + (acc_lo[0] ? {1'b0, mcand} : '0);
`endif

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q       <= OP_MULT;
      acc_hi     <= '0;
      acc_lo     <= '0;
      mcand      <= '0;
      mag_b      <= '0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      booth_x    <= 1'b0;
`endif
      result_lo  <= '0;
      result_hi  <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
    end else begin
      result_rdy <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start_mult) begin
            op_q      <= OP_MULT;
            exception <= 1'b0;
            acc_hi    <= '0;
`ifdef MULTDIV_BOOTH4_EN
            // Booth works on the signed operands directly
            mcand     <= op_a;
            acc_lo    <= op_b;
            neg_lo    <= 1'b0;
            booth_x   <= 1'b0;
`else
            mcand     <= a_mag;
            acc_lo    <= b_mag;
            neg_lo    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`endif
          end else if (start_div) begin
            op_q      <= OP_DIV;
            exception <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= a_mag;
            mag_b     <= b_mag;
            neg_lo    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_hi    <= op_a[WIDTH-1];
          end
        end
        MULT: begin
`ifdef MULTDIV_BOOTH4_EN
          acc_hi  <= {{2{booth_sum[HW-1]}}, booth_sum[HW-1:2]};
          acc_lo  <= {booth_sum[1:0], acc_lo[WIDTH-1:2]};
          booth_x <= acc_lo[1];
`else
          acc_hi  <= {1'b0, mul_sum[WIDTH:1]};
          acc_lo  <= {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
        end
        DIV: begin
          if (mag_b != '0) begin
            acc_hi <= div_diff[WIDTH+1] ? HW'(div_shift) : HW'(div_diff[WIDTH:0]);
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
          end
        end
        DONE: begin
          if (op_q == OP_MULT) begin
            {result_hi, result_lo} <= prod_fix;
            exception <= (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
          end else if (mag_b == '0) begin
            result_lo <= '0;
            result_hi <= a_fix;
            exception <= 1'b1;
          end else begin
            result_lo <= q_fix;
            result_hi <= r_fix;
            exception <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] op_a, op_b;
  logic        start_mult, start_div;
  logic [31:0] result_lo, result_hi;
  logic        exception, result_rdy, busy;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MULT_LAT = 17;
`else
  localparam int MULT_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk       (clk),
    .clr       (clr),
    .op_a      (op_a),
    .op_b      (op_b),
    .start_mult(start_mult),
    .start_div (start_div),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .exception (exception),
    .result_rdy(result_rdy),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on 64-bit / 32-bit integers.
  task automatic model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi,
                       output logic exc, output int lat);
    longint p;
    int     q, r;
    if (mult) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      lo  = p[31:0];
      hi  = p[63:32];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      lat = MULT_LAT;
    end else if (b == 32'd0) begin
      lo = 32'd0; hi = a; exc = 1'b1; lat = 2;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000; hi = 32'd0; exc = 1'b0; lat = DIV_LAT;
    end else begin
      q  = $signed(a) / $signed(b);
      r  = $signed(a) % $signed(b);
      lo = q; hi = r; exc = 1'b0; lat = DIV_LAT;
    end
  endtask

  // Issue one operation (entered ~1 ns after an edge), check latency,
  // results, pulse width and hold. disturb>0 pulses start_div that many
  // cycles into the operation.
  task automatic do_op(input bit mult, input logic [31:0] a, input logic [31:0] b,
                       input int disturb, input string tag);
    logic [31:0] elo, ehi;
    logic        eexc;
    int          elat, n;
    model(mult, a, b, elo, ehi, eexc, elat);
    op_a = a; op_b = b;
    start_mult = mult; start_div = !mult;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0;
    op_a = $urandom; op_b = $urandom;
    check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (!result_rdy && n < 100) begin
      if (n == disturb) start_div = 1'b1;
      @(posedge clk); #1;
      start_div = 1'b0;
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_lo"}, result_lo, elo);
    check({tag, "_hi"}, result_hi, ehi);
    check({tag, "_exc"}, exception, eexc);
    @(posedge clk); #1;
    check({tag, "_pulse"}, result_rdy, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_hold"}, {result_hi, result_lo}, {ehi, elo});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 400)) - 32'd200;
      2:       return {16'd0, 16'($urandom)};
      3:       return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
    endcase
  endfunction

  initial begin
    bit seen;
    clr = 1'b0; op_a = '0; op_b = '0; start_mult = 1'b0; start_div = 1'b0;

    // reset held with start pulses toggling
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start_mult = i[0]; start_div = ~i[0]; op_a = $urandom; op_b = $urandom;
      seen |= result_rdy | busy;
    end
    start_mult = 1'b0; start_div = 1'b0;
    check("rst_lo", result_lo, 32'd0);
    check("rst_hi", result_hi, 32'd0);
    check("rst_exc", exception, 1'b0);
    check("rst_rdy", result_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_activity", seen, 1'b0);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;

    // directed cases
    do_op(1'b1, 32'd7, 32'hFFFF_FFFA, -1, "mul_7xm6");
    do_op(1'b1, 32'h0001_0000, 32'h0001_0000, -1, "mul_ovf");
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, -1, "mul_minxmin");
    do_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, -1, "mul_m1xmin");
    do_op(1'b0, 32'hFFFF_FFF9, 32'd2, -1, "div_m7d2");
    do_op(1'b0, 32'd5, 32'd0, -1, "div_by0");
    do_op(1'b0, 32'hFFFF_FFFB, 32'd0, -1, "div_neg_by0");
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_min_m1");
    do_op(1'b0, 32'd100, 32'hFFFF_FFF9, -1, "div_100dm7");

    // start_div during a multiply must be ignored
    do_op(1'b1, 32'd12345, 32'hFFFF_FFB3, 5, "mul_ignore_div");

    // randomized mix
    for (int i = 0; i < 24; i++)
      do_op(1'($urandom_range(0, 1)), rnd_operand(), rnd_operand(), -1, "rand");

    // abort: clr at iteration 10 of a multiply
    op_a = 32'd3; op_b = 32'd4; start_mult = 1'b1;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (10) @(posedge clk);
    #1 clr = 1'b0;
    #1 check("abort_busy", busy, 1'b0);
    check("abort_lo", result_lo, 32'd0);
    @(posedge clk); #1 clr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= result_rdy | busy;
    end
    check("abort_no_rdy", seen, 1'b0);
    do_op(1'b0, 32'd1000, 32'd7, -1, "after_abort_div");
    do_op(1'b1, 32'hFFFF_FFF0, 32'd9, -1, "after_abort_mul");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
